i2c_write_arbiter: RTL and testbench



---
 rtl/i2c_write_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_i2c_write_arbiter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_write_arbiter.sv
// i2c_write_arbiter
// Round-robin arbiter sharing one single-byte I2C write master among NUM_REQ
// requesters. A winner's address/data are latched, a one-cycle start pulse
// is issued, the master's busy handshake is tracked under a watchdog, and a
// per-requester done pulse with an error flag closes the transfer.
//
// Ports:
//   i_Clk, i_Rst        clock, synchronous active-high reset
//   i_Req[NUM_REQ]      level requests, held until own o_Done
//   i_Req_Addr/Data     packed per-requester 7-bit address / 8-bit byte
//   o_Grant             one-hot grant, latch through completion
//   o_Done              one-cycle completion pulse of the granted requester
//   o_Error             result of the last completed transfer
//   o_Busy              arbiter owns the master
//   o_Wr_Start          one-cycle start pulse to the master
//   o_Slave_Addr/o_Wr_Byte  latched transfer parameters to the master
//   i_Busy, i_Error     master handshake / error flag
module i2c_write_arbiter #(
  parameter int          NUM_REQ = 4,
  parameter logic [15:0] TIMEOUT = 16'd4095
) (
  input  logic                 i_Clk,
  input  logic                 i_Rst,
  input  logic [NUM_REQ-1:0]   i_Req,
  input  logic [7*NUM_REQ-1:0] i_Req_Addr,
  input  logic [8*NUM_REQ-1:0] i_Req_Data,
  output logic [NUM_REQ-1:0]   o_Grant,
  output logic [NUM_REQ-1:0]   o_Done,
  output logic                 o_Error,
  output logic                 o_Busy,
  output logic                 o_Wr_Start,
  output logic [6:0]           o_Slave_Addr,
  output logic [7:0]           o_Wr_Byte,
  input  logic                 i_Busy,
  input  logic                 i_Error
);

  localparam int IW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int IW1 = IW + 1;

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT_HI, S_WAIT_LO, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [IW-1:0]        ptr_q, ptr_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [15:0]          cnt_q, cnt_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [NUM_REQ-1:0]   done_q, done_d;
  logic                 error_q, error_d;
  logic                 busy_q, busy_d;
  logic                 wr_start_q, wr_start_d;
  logic [6:0]           addr_q, addr_d;
  logic [7:0]           byte_q, byte_d;

  // Round-robin pick: first requester at or after ptr, wrapping.
  logic          found;
  logic [IW-1:0] sel;
  logic [IW:0]   cand;
  always_comb begin
    found = 1'b0;
    sel   = '0;
    cand  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, ptr_q} + IW1'(i);
      if (cand >= IW1'(NUM_REQ)) cand = cand - IW1'(NUM_REQ);
      if (!found && i_Req[cand[IW-1:0]]) begin
        found = 1'b1;
        sel   = cand[IW-1:0];
      end
    end
  end

  logic finish, fin_err;
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    grant_d    = grant_q;
    done_d     = '0;
    error_d    = error_q;
    busy_d     = busy_q;
    wr_start_d = 1'b0;
    addr_d     = addr_q;
    byte_d     = byte_q;
    finish     = 1'b0;
    fin_err    = 1'b0;

    case (state_q)
      S_IDLE: begin
        // A master still busy (e.g. after an arbiter reset) blocks new grants.
        if (!i_Busy && found) begin
          idx_d        = sel;
          addr_d       = i_Req_Addr[7*sel +: 7];
          byte_d       = i_Req_Data[8*sel +: 8];
          grant_d      = '0;
          grant_d[sel] = 1'b1;
          busy_d       = 1'b1;
          state_d      = S_ISSUE;
        end
      end
      S_ISSUE: begin
        wr_start_d = 1'b1;
        cnt_d      = '0;
        state_d    = S_WAIT_HI;
      end
      S_WAIT_HI: begin
        if (i_Busy) begin
          cnt_d   = '0;
          state_d = S_WAIT_LO;
        end else if (cnt_q == TIMEOUT) begin
          finish  = 1'b1;
          fin_err = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_WAIT_LO: begin
        if (!i_Busy) begin
          finish  = 1'b1;
          fin_err = i_Error;
        end else if (cnt_q == TIMEOUT) begin
          finish  = 1'b1;
          fin_err = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Completion outputs are registered on entry so o_Done coincides with DONE.
    if (finish) begin
      state_d = S_DONE;
      done_d  = grant_q;
      error_d = fin_err;
      grant_d = '0;
      busy_d  = 1'b0;
      ptr_d   = (idx_q == IW'(NUM_REQ-1)) ? '0 : idx_q + IW'(1);
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      idx_q      <= '0;
      cnt_q      <= '0;
      grant_q    <= '0;
      done_q     <= '0;
      error_q    <= 1'b0;
      busy_q     <= 1'b0;
      wr_start_q <= 1'b0;
      addr_q     <= '0;
      byte_q     <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      grant_q    <= grant_d;
      done_q     <= done_d;
      error_q    <= error_d;
      busy_q     <= busy_d;
      wr_start_q <= wr_start_d;
      addr_q     <= addr_d;
      byte_q     <= byte_d;
    end
  end

  assign o_Grant      = grant_q;
  assign o_Done       = done_q;
  assign o_Error      = error_q;
  assign o_Busy       = busy_q;
  assign o_Wr_Start   = wr_start_q;
  assign o_Slave_Addr = addr_q;
  assign o_Wr_Byte    = byte_q;

endmodule

// File: tb/tb_i2c_write_arbiter.sv
// Bench for i2c_write_arbiter: directed transfers, a behavioural master, and a
// scoreboard queue checked by an independent monitor.
module tb_i2c_write_arbiter;
  localparam int          N  = 4;
  // Watchdog shortened so a stuck master completes quickly but a 20-cycle
  // transfer still fits; a never-busy master finishes TO+1 cycles after start.
  localparam logic [15:0] TO = 16'd24;

  logic           clk = 1'b0;
  logic           i_Rst;
  logic [N-1:0]   i_Req;
  logic [7*N-1:0] i_Req_Addr;
  logic [8*N-1:0] i_Req_Data;
  logic [N-1:0]   o_Grant, o_Done;
  logic           o_Error, o_Busy, o_Wr_Start;
  logic [6:0]     o_Slave_Addr;
  logic [7:0]     o_Wr_Byte;
  logic           i_Busy, i_Error;

  always #5 clk = ~clk;

  i2c_write_arbiter #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
    .i_Clk(clk), .i_Rst(i_Rst), .i_Req(i_Req), .i_Req_Addr(i_Req_Addr),
    .i_Req_Data(i_Req_Data), .o_Grant(o_Grant), .o_Done(o_Done),
    .o_Error(o_Error), .o_Busy(o_Busy), .o_Wr_Start(o_Wr_Start),
    .o_Slave_Addr(o_Slave_Addr), .o_Wr_Byte(o_Wr_Byte),
    .i_Busy(i_Busy), .i_Error(i_Error)
  );

  int nvec = 0, nmis = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    int         idx;
    logic [6:0] addr;
    logic [7:0] data;
    logic       err;
    int         lat;   // cycles start->done, 0 = not checked
  } exp_t;
  exp_t sb[$];

  task automatic push(input int k, input logic [6:0] a, input logic [7:0] d,
                      input logic e, input int lat);
    exp_t x;
    x.idx = k; x.addr = a; x.data = d; x.err = e; x.lat = lat;
    sb.push_back(x);
  endtask

  // Behavioural master: busy one cycle after start, held busy_len cycles.
  int   busy_len   = 20;
  bit   mst_nobusy = 1'b0;
  logic mst_err    = 1'b0;
  initial begin
    i_Busy = 1'b0; i_Error = 1'b0;
    forever begin
      @(negedge clk);
      if (o_Wr_Start === 1'b1 && !mst_nobusy) begin
        @(negedge clk);
        i_Busy = 1'b1;
        repeat (busy_len) @(negedge clk);
        i_Error = mst_err;
        i_Busy  = 1'b0;
      end
    end
  end

  // Monitor: samples 1 time unit after each rising edge.
  int cyc = 0, t_start = 0;
  logic prev_start = 1'b0;
  always @(posedge clk) begin
    exp_t e;
    #1;
    cyc++;
    if (o_Wr_Start === 1'b1) begin
      chk("start_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        chk("start_addr",  32'(o_Slave_Addr), 32'(sb[0].addr));
        chk("start_data",  32'(o_Wr_Byte),    32'(sb[0].data));
        chk("start_grant", 32'(o_Grant),      32'(1 << sb[0].idx));
      end
      chk("start_idle_master", 32'(i_Busy), 32'd0);
      if (prev_start) chk("start_one_cycle", 32'(prev_start), 32'd0);
      t_start = cyc;
    end
    prev_start = (o_Wr_Start === 1'b1);
    if (!$onehot0(o_Grant)) chk("grant_onehot", 32'(o_Grant), 32'd0);
    if (o_Done !== '0 && !i_Rst) begin
      if (sb.size() == 0) chk("done_unexpected", 32'(o_Done), 32'd0);
      else begin
        e = sb.pop_front();
        chk("done_vec",   32'(o_Done),       32'(1 << e.idx));
        chk("done_error", 32'(o_Error),      32'(e.err));
        chk("done_addr",  32'(o_Slave_Addr), 32'(e.addr));
        chk("done_grant", 32'(o_Grant),      32'd0);
        if (e.lat != 0) chk("done_latency", 32'(cyc - t_start), 32'(e.lat));
      end
    end
  end

  task automatic set_req(input int k, input logic [6:0] a, input logic [7:0] d);
    i_Req_Addr[7*k +: 7] = a;
    i_Req_Data[8*k +: 8] = d;
  endtask

  task automatic wait_done(input int k);
    int n = 0;
    while (o_Done[k] !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_xfer(input int k, input logic [6:0] a, input logic [7:0] d,
                         input logic e, input int lat);
    set_req(k, a, d);
    push(k, a, d, e, lat);
    i_Req[k] = 1'b1;
    wait_done(k);
    i_Req[k] = 1'b0;
    @(negedge clk);
  endtask

  // Each requester drops its request after its c-th done pulse.
  task automatic run_batch(input int c0, input int c1, input int c2, input int c3);
    int c[4];
    int n = 0;
    c = '{c0, c1, c2, c3};
    for (int k = 0; k < 4; k++) if (c[k] > 0) i_Req[k] = 1'b1;
    while ((c[0] + c[1] + c[2] + c[3]) > 0 && n < 1000) begin
      @(negedge clk);
      n++;
      for (int k = 0; k < 4; k++)
        if (o_Done[k] === 1'b1 && c[k] > 0) begin
          c[k]--;
          if (c[k] == 0) i_Req[k] = 1'b0;
        end
    end
    if (n >= 1000) chk("batch_timeout", 32'd0, 32'd1);
    @(negedge clk);
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk(nm, 32'({o_Grant, o_Done, o_Error, o_Busy, o_Wr_Start}), 32'd0);
    chk({nm, "_addr"}, 32'({o_Slave_Addr, o_Wr_Byte}), 32'd0);
  endtask

  initial begin
    i_Rst = 1'b1; i_Req = '0; i_Req_Addr = '0; i_Req_Data = '0;
    repeat (2) @(negedge clk);
    i_Rst = 1'b0;
    chk_reset_outputs("reset_state");

    // Single request from requester 1.
    do_xfer(1, 7'h3C, 8'hA5, 1'b0, 0);

    // ptr now 2: simultaneous 0 and 3 must serve 3 first.
    set_req(3, 7'h33, 8'h33); set_req(0, 7'h30, 8'h30);
    push(3, 7'h33, 8'h33, 1'b0, 0);
    push(0, 7'h30, 8'h30, 1'b0, 0);
    run_batch(1, 0, 0, 1);

    // All requesting from reset: 0,1,2,3,0.
    i_Rst = 1'b1; @(negedge clk); i_Rst = 1'b0;
    for (int k = 0; k < 4; k++) set_req(k, 7'(7'h40 + k), 8'(8'hC0 + k));
    for (int k = 0; k < 4; k++) push(k, 7'(7'h40 + k), 8'(8'hC0 + k), 1'b0, 0);
    push(0, 7'h40, 8'hC0, 1'b0, 0);
    run_batch(2, 1, 1, 1);

    // Master never responds: watchdog error, then normal transfer.
    mst_nobusy = 1'b1;
    do_xfer(2, 7'h52, 8'h5A, 1'b1, int'(TO) + 1);
    mst_nobusy = 1'b0;
    do_xfer(1, 7'h11, 8'h22, 1'b0, 0);

    // Master reports an error.
    mst_err = 1'b1;
    do_xfer(3, 7'h77, 8'hEE, 1'b1, 0);
    mst_err = 1'b0;

    // Reset during WAIT_LO: aborted silently, waits for master, then regrants.
    set_req(0, 7'h15, 8'h51);
    push(0, 7'h15, 8'h51, 1'b0, 0);
    i_Req[0] = 1'b1;
    begin
      int n = 0;
      while (i_Busy !== 1'b1 && n < 100) begin @(negedge clk); n++; end
      if (n >= 100) chk("master_busy_timeout", 32'd0, 32'd1);
    end
    repeat (3) @(negedge clk);
    sb.delete();
    i_Rst = 1'b1; i_Req[0] = 1'b0;
    @(negedge clk);
    i_Rst = 1'b0;
    chk_reset_outputs("midxfer_reset");
    i_Req[0] = 1'b1;
    push(0, 7'h15, 8'h51, 1'b0, 0);
    wait_done(0);
    i_Req[0] = 1'b0;
    @(negedge clk);

    // Clean transfer after error returns o_Error=0.
    do_xfer(3, 7'h78, 8'h01, 1'b0, 0);

    // Address change after grant must not reach the master.
    set_req(0, 7'h10, 8'h66);
    push(0, 7'h10, 8'h66, 1'b0, 0);
    i_Req[0] = 1'b1;
    begin
      int n = 0;
      while (o_Grant[0] !== 1'b1 && n < 100) begin @(negedge clk); n++; end
      if (n >= 100) chk("grant_timeout", 32'd0, 32'd1);
    end
    set_req(0, 7'h20, 8'h99);
    wait_done(0);
    i_Req[0] = 1'b0;

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
